mem_port_arbiter: RTL and testbench

//  Shares one single-ported memory between the instruction-fetch and data-access requesters of the core.

---
 rtl/mem_port_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between the fetch (i_*) and data (d_*) requesters, one transaction at a time.
// Build option: define ARB_ROUND_ROBIN_EN for alternating tie-break; default is fixed priority with data winning ties.
module mem_port_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_ack,
  output logic          i_err,
  output logic [DW-1:0] i_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic          d_err,
  output logic [DW-1:0] d_rdata,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_gnt,
  input  logic          mem_rvalid,
  input  logic [DW-1:0] mem_rdata,
  output logic [1:0]    dbg_state_o,
  output logic          dbg_last_grant_o
);

  // Handshakes: a requester holds req and its address/data until its one-cycle ack;
  // mem_req is held until the cycle mem_gnt is seen; mem_rvalid is honoured only in RESP.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2,
    S_ACK  = 2'd3
  } state_e;

  // Wide enough to hold TIMEOUT, which is reached when grant arrives on the last allowed cycle.
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          win_q, win_d;       // 1 = data port owns the transaction
  logic          last_q, last_d;     // 1 = data port won most recently
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          i_ack_q, i_ack_d, i_err_q, i_err_d;
  logic          d_ack_q, d_ack_d, d_err_q, d_err_d;
  logic [DW-1:0] i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;

  logic tie_data;
  logic pick_data;
  logic timed_out;
  logic done;
  logic fail;

`ifdef ARB_ROUND_ROBIN_EN
  assign tie_data = ~last_q;
`else
  assign tie_data = 1'b1;
`endif

  assign pick_data = d_req & (~i_req | tie_data);
  assign timed_out = (cnt_q >= CNT_LAST);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    win_d       = win_q;
    last_d      = last_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    i_ack_d     = 1'b0;
    i_err_d     = 1'b0;
    d_ack_d     = 1'b0;
    d_err_d     = 1'b0;
    done        = 1'b0;
    fail        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (i_req || d_req) begin
          state_d     = S_REQ;
          cnt_d       = '0;
          win_d       = pick_data;
          last_d      = pick_data;
          mem_req_d   = 1'b1;
          mem_we_d    = pick_data & d_we;
          mem_addr_d  = pick_data ? d_addr : i_addr;
          // Fetch has no store data; drive zeros rather than stale data-port values.
          mem_wdata_d = pick_data ? d_wdata : '0;
        end
      end
      S_REQ: begin
        cnt_d = cnt_q + CW'(1);
        if (mem_gnt) begin
          mem_req_d = 1'b0;
          if (mem_we_q) done = 1'b1;
          else          state_d = S_RESP;
        end else if (timed_out) begin
          mem_req_d = 1'b0;
          fail      = 1'b1;
        end
      end
      S_RESP: begin
        cnt_d = cnt_q + CW'(1);
        if (mem_rvalid) begin
          done = 1'b1;
          if (win_q) d_rdata_d = mem_rdata;
          else       i_rdata_d = mem_rdata;
        end else if (timed_out) begin
          fail = 1'b1;
        end
      end
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (done || fail) begin
      state_d = S_ACK;
      i_ack_d = ~win_q;
      d_ack_d = win_q;
      i_err_d = fail & ~win_q;
      d_err_d = fail & win_q;
    end
    if (fail) begin
      if (win_q) d_rdata_d = '0;
      else       i_rdata_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      win_q       <= 1'b0;
      last_q      <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_ack_q     <= 1'b0;
      i_err_q     <= 1'b0;
      d_ack_q     <= 1'b0;
      d_err_q     <= 1'b0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      win_q       <= win_d;
      last_q      <= last_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      i_ack_q     <= i_ack_d;
      i_err_q     <= i_err_d;
      d_ack_q     <= d_ack_d;
      d_err_q     <= d_err_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign i_ack            = i_ack_q;
  assign i_err            = i_err_q;
  assign i_rdata          = i_rdata_q;
  assign d_ack            = d_ack_q;
  assign d_err            = d_err_q;
  assign d_rdata          = d_rdata_q;
  assign mem_req          = mem_req_q;
  assign mem_we           = mem_we_q;
  assign mem_addr         = mem_addr_q;
  assign mem_wdata        = mem_wdata_q;
  assign dbg_state_o      = state_q;
  assign dbg_last_grant_o = last_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-level reference model checked every cycle plus directed scenarios.
module tb_mem_port_arbiter;
  localparam int AW      = 32;
  localparam int DW      = 32;
  localparam int TIMEOUT = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_req, d_req, d_we;
  logic [AW-1:0] i_addr, d_addr;
  logic [DW-1:0] d_wdata;
  logic          i_ack, i_err, d_ack, d_err;
  logic [DW-1:0] i_rdata, d_rdata;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_gnt = 1'b0, mem_rvalid = 1'b0;
  logic [DW-1:0] mem_rdata = '0;
  logic [1:0]    dbg_state_o;
  logic          dbg_last_grant_o;

  mem_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_err(i_err), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_err(d_err), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .dbg_state_o(dbg_state_o), .dbg_last_grant_o(dbg_last_grant_o)
  );

  // ---------------- clock / reset / cycle counter ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int  n_checks = 0;
  int  n_errors = 0;
  bit  chk_en   = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- memory responder ----------------
  int            gnt_delay = 0;
  int            gnt_wait  = 0;
  bit            rvalid_en = 1'b1;
  bit            rd_due, rd_next;
  bit            stray_pend = 1'b0;
  logic [DW-1:0] rdata_val  = '0;
  logic [DW-1:0] stray_data = '0;

  always @(posedge clk) begin
    #1;
    rd_due  = rd_next;
    rd_next = 1'b0;
    if (mem_req === 1'b1) begin
      mem_gnt = (gnt_wait >= gnt_delay);
      gnt_wait++;
      rd_next = mem_gnt && (mem_we === 1'b0);
    end else begin
      mem_gnt  = 1'b0;
      gnt_wait = 0;
    end
    if (stray_pend) begin
      mem_rvalid = 1'b1;
      mem_rdata  = stray_data;
      stray_pend = 1'b0;
    end else begin
      mem_rvalid = rd_due && rvalid_en;
      mem_rdata  = rd_due ? rdata_val : '0;
    end
  end

  // ---------------- reference model (one transaction in flight) ----------------
  bit            m_busy, m_acking, m_port, m_we, m_granted, m_last;
  int            m_age;
  logic          e_mem_req, e_mem_we, e_i_ack, e_i_err, e_d_ack, e_d_err;
  logic [AW-1:0] e_mem_addr;
  logic [DW-1:0] e_mem_wdata, e_i_rdata, e_d_rdata;

  task automatic m_complete(input bit err, input bit load, input logic [DW-1:0] data);
    m_busy   = 1'b0;
    m_acking = 1'b1;
    if (m_port) begin
      e_d_ack = 1'b1; e_d_err = err;
      if (load) e_d_rdata = data;
    end else begin
      e_i_ack = 1'b1; e_i_err = err;
      if (load) e_i_rdata = data;
    end
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      m_busy = 0; m_acking = 0; m_port = 0; m_we = 0; m_granted = 0; m_last = 0; m_age = 0;
      e_mem_req = 0; e_mem_we = 0; e_mem_addr = '0; e_mem_wdata = '0;
      e_i_ack = 0; e_i_err = 0; e_d_ack = 0; e_d_err = 0; e_i_rdata = '0; e_d_rdata = '0;
    end else begin
      e_i_ack = 0; e_i_err = 0; e_d_ack = 0; e_d_err = 0;
      if (m_acking) begin
        m_acking = 1'b0;
      end else if (!m_busy) begin
        if (i_req || d_req) begin
          if (i_req && d_req) begin
`ifdef ARB_ROUND_ROBIN_EN
            m_port = ~m_last;
`else
            m_port = 1'b1;
`endif
          end else begin
            m_port = d_req;
          end
          m_last      = m_port;
          m_busy      = 1'b1;
          m_granted   = 1'b0;
          m_age       = 0;
          m_we        = m_port && d_we;
          e_mem_req   = 1'b1;
          e_mem_we    = m_we;
          e_mem_addr  = m_port ? d_addr : i_addr;
          e_mem_wdata = m_port ? d_wdata : '0;
        end
      end else begin
        m_age++;
        if (!m_granted && mem_gnt) begin
          e_mem_req = 1'b0;
          if (m_we) m_complete(1'b0, 1'b0, '0);
          else      m_granted = 1'b1;
        end else if (m_granted && mem_rvalid) begin
          m_complete(1'b0, 1'b1, mem_rdata);
        end else if (m_age >= TIMEOUT) begin
          e_mem_req = 1'b0;
          m_complete(1'b1, 1'b1, '0);
        end
      end
    end
  end

  // ---------------- per-cycle compare + monitor ----------------
  int            i_ack_n = 0, d_ack_n = 0, mreq_cycles = 0;
  logic [AW-1:0] seen_addr;
  logic [DW-1:0] seen_wdata;

  always @(negedge clk) begin
    if (i_ack === 1'b1) i_ack_n++;
    if (d_ack === 1'b1) d_ack_n++;
    if (mem_req === 1'b1) begin
      mreq_cycles++;
      seen_addr  = mem_addr;
      seen_wdata = mem_wdata;
    end
    if (chk_en) begin
      check("mem_req",    mem_req,   e_mem_req);
      check("mem_we",     mem_we,    e_mem_we);
      check("mem_addr",   mem_addr,  e_mem_addr);
      check("mem_wdata",  mem_wdata, e_mem_wdata);
      check("i_ack",      i_ack,     e_i_ack);
      check("i_err",      i_err,     e_i_err);
      check("i_rdata",    i_rdata,   e_i_rdata);
      check("d_ack",      d_ack,     e_d_ack);
      check("d_err",      d_err,     e_d_err);
      check("d_rdata",    d_rdata,   e_d_rdata);
      check("last_grant", dbg_last_grant_o, m_last);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_ack(input bit port, output int c, output bit err);
    c = -1; err = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if ((port ? d_ack : i_ack) === 1'b1) begin
        c = cyc; err = port ? d_err : i_err;
        return;
      end
    end
    n_checks++; n_errors++;
    $display("FAIL wait_ack_port%0d: got no ack expected ack within 100 cycles", port);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #2 rst_n = 1'b0;
    @(posedge clk); #2 rst_n = 1'b1;
  endtask

  logic [0:0] exp_q[$];
  logic [0:0] got_q[$];

  initial begin
    int t0, c1, c2, n_i, n_d, last_c;
    bit e;
    rst_n = 1'b0; i_req = 0; d_req = 0; d_we = 0; i_addr = '0; d_addr = '0; d_wdata = '0;
    @(posedge clk);
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_state",   dbg_state_o, 2'd0);
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_acks",    {i_ack, d_ack, i_err, d_err}, 4'b0);
    check("rst_rdata",   {i_rdata, d_rdata}, 64'h0);
    @(posedge clk); #2 rst_n = 1'b1;

    // 1: single fetch, zero-wait memory
    @(posedge clk); #2;
    t0 = cyc; rdata_val = 32'hDEADBEEF; i_addr = 32'h10; i_req = 1'b1; n_d = d_ack_n;
    wait_ack(1'b0, c1, e);
    @(posedge clk); #2 i_req = 1'b0;
    check("t1_latency", c1 - t0, 3);
    check("t1_mem_addr", seen_addr, 32'h10);
    check("t1_rdata", i_rdata, 32'hDEADBEEF);
    check("t1_err", e, 1'b0);
    check("t1_no_d_ack", d_ack_n - n_d, 0);

    // 2: data write, grant delayed two cycles
    @(posedge clk); #2;
    gnt_delay = 2; mreq_cycles = 0; n_i = i_ack_n;
    t0 = cyc; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'h1234; d_req = 1'b1;
    wait_ack(1'b1, c1, e);
    @(posedge clk); #2 d_req = 1'b0; d_we = 1'b0; gnt_delay = 0;
    check("t2_latency", c1 - t0, 4);
    check("t2_mreq_cycles", mreq_cycles, 3);
    check("t2_mem_wdata", seen_wdata, 32'h1234);
    check("t2_mem_addr", seen_addr, 32'h20);
    check("t2_err", e, 1'b0);
    check("t2_no_i_ack", i_ack_n - n_i, 0);

    // 3: both ports held high for three transactions, from a fresh last_grant
    pulse_reset();
`ifdef ARB_ROUND_ROBIN_EN
    exp_q = '{1'b1, 1'b0, 1'b1};
`else
    exp_q = '{1'b1, 1'b1, 1'b1};
`endif
    got_q.delete(); last_c = -1;
    @(posedge clk); #2;
    t0 = cyc; rdata_val = 32'hA5A5A5A5;
    i_addr = 32'h34; d_addr = 32'h30; i_req = 1'b1; d_req = 1'b1;
    for (int k = 0; k < 100 && got_q.size() < 3; k++) begin
      @(negedge clk);
      if (d_ack === 1'b1) begin got_q.push_back(1'b1); last_c = cyc; end
      if (i_ack === 1'b1) begin got_q.push_back(1'b0); last_c = cyc; end
    end
    @(posedge clk); #2 i_req = 1'b0; d_req = 1'b0;
    check("t3_count", got_q.size(), 3);
    for (int k = 0; k < 3; k++) begin
      if (k < got_q.size()) check($sformatf("t3_grant%0d", k), got_q[k], exp_q[k]);
    end
    check("t3_last_ack_cycle", last_c - t0, 11);
    check("t3_d_rdata", d_rdata, 32'hA5A5A5A5);

    // 4: read whose data never returns
    @(posedge clk); #2;
    rvalid_en = 1'b0; t0 = cyc; d_we = 1'b0; d_addr = 32'h44; d_req = 1'b1;
    wait_ack(1'b1, c1, e);
    check("t4_latency", c1 - t0, TIMEOUT + 1);
    check("t4_err", e, 1'b1);
    @(posedge clk); #2 d_req = 1'b0; rvalid_en = 1'b1;
    @(negedge clk);
    check("t4_idle", dbg_state_o, 2'd0);
    check("t4_rdata_zero", d_rdata, 32'h0);
    check("t4_ack_dropped", d_ack, 1'b0);

    // 5: stray rvalid while idle, then held fetch re-granted after IDLE
    @(posedge clk); #2 stray_data = 32'h99; stray_pend = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check("t5_stray_ignored", d_rdata, 32'h0);
    t0 = cyc; rdata_val = 32'h55; i_addr = 32'h50; i_req = 1'b1;
    wait_ack(1'b0, c1, e);
    check("t5_latency", c1 - t0, 3);
    check("t5_rdata", i_rdata, 32'h55);
    @(negedge clk);
    check("t5_ack_pulse", i_ack, 1'b0);
    check("t5_idle_no_req", mem_req, 1'b0);
    @(negedge clk);
    check("t5_regrant", mem_req, 1'b1);
    wait_ack(1'b0, c2, e);
    @(posedge clk); #2 i_req = 1'b0;
    check("t5_second_ack_gap", c2 - c1, 4);

    // 6: reset while waiting in RESP
    @(posedge clk); #2;
    rvalid_en = 1'b0; n_i = i_ack_n; i_addr = 32'h60; i_req = 1'b1;
    @(posedge clk);
    @(posedge clk); #2 rst_n = 1'b0; i_req = 1'b0;
    @(negedge clk);
    check("t6_in_resp", dbg_state_o, 2'd2);
    @(negedge clk);
    check("t6_idle", dbg_state_o, 2'd0);
    check("t6_mem_req", mem_req, 1'b0);
    check("t6_no_ack", {i_ack, i_err}, 2'b00);
    @(posedge clk); #2 rst_n = 1'b1; rvalid_en = 1'b1;
    repeat (4) @(posedge clk);
    #2;
    check("t6_no_late_ack", i_ack_n - n_i, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    n_errors++;
    $display("FAIL watchdog: got still running expected finished");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "watchdog expired");
  end

endmodule
